// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
// UART receive engine. Oversamples the serial line at i_prescale clocks per
// bit, qualifies start bits, takes a 3-sample majority vote in the middle of
// every bit, shifts data in LSB-first and checks parity and stop. A good byte
// appears on o_data with a single-cycle o_data_valid pulse. A parity or stop
// failure gives a single-cycle o_par_err / o_stop_err pulse and no valid pulse.
//
// Build option: UART_RX_SYNC_EN
//   defined   - i_rx_in goes through a 2-flop synchroniser (reset value 1),
//               which adds 2 cycles to every latency
//   undefined - i_rx_in is used directly and must already be synchronous
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_rx_in       serial line, idle high
//   i_prescale    clocks per bit (even, 8..32), captured at frame start
//   i_en_par      frame carries a parity bit, captured at frame start
//   i_par_typ     0 = even parity, 1 = odd parity, captured at frame start
//   o_data        last good byte, held until the next good frame
//   o_data_valid  1-cycle pulse, o_data updated in the same cycle
//   o_par_err     1-cycle pulse at frame end on parity mismatch
//   o_stop_err    1-cycle pulse at frame end when the stop bit reads 0
//   o_busy        high whenever the FSM is not idle
//
// state | meaning
// IDLE  | line idle, waiting for a low level
// START | timing the start bit, vote 1 rejects it as a glitch
// DATA  | receiving DATA_WIDTH payload bits
// PAR   | receiving the parity bit
// STOP  | receiving the stop bit, frame result issued at its end
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRE_W      = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_in,
    input  logic [PRE_W-1:0]      i_prescale,
    input  logic                  i_en_par,
    input  logic                  i_par_typ,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stop_err,
    output logic                  o_busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic                    rx;
    logic [PRE_W-1:0]        edge_cnt;
    logic [PRE_W-1:0]        p_q;
    logic [PRE_W-1:0]        half;
    logic                    ep_q;
    logic                    pt_q;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [2:0]              smp_q;
    logic                    par_bad;
    logic                    wait_high;
    logic                    bit_end;
    logic                    vote;
    logic                    start_frame;
    logic                    shift_en;
    logic                    par_chk;
    logic                    frame_done;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx_in};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = i_rx_in;
`endif

    assign half    = p_q >> 1;
    assign bit_end = (edge_cnt == p_q - PRE_W'(1));
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign o_busy  = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_chk     = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx && !wait_high) begin
                    state_nxt   = S_START;
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        state_nxt = ep_q ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    par_chk   = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    frame_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            edge_cnt     <= '0;
            p_q          <= '0;
            ep_q         <= 1'b0;
            pt_q         <= 1'b0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            smp_q        <= '0;
            par_bad      <= 1'b0;
            wait_high    <= 1'b0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stop_err   <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stop_err   <= 1'b0;

            if (state == S_IDLE || state_nxt != state || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRE_W'(1);
            end

            if (state != S_IDLE) begin
                if (edge_cnt == half - PRE_W'(1)) smp_q[0] <= rx;
                if (edge_cnt == half)             smp_q[1] <= rx;
                if (edge_cnt == half + PRE_W'(1)) smp_q[2] <= rx;
            end

            if (start_frame) begin
                p_q     <= i_prescale;
                ep_q    <= i_en_par;
                pt_q    <= i_par_typ;
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end

            if (shift_en) begin
                shift_q <= {vote, shift_q[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (par_chk) begin
                par_bad <= (vote != (^shift_q ^ pt_q));
            end

            // An all-zero frame with a bad stop bit is a line break: hold off
            // new starts until the line has been seen high again, otherwise
            // the low line would retrigger immediately.
            if (state == S_IDLE && rx) begin
                wait_high <= 1'b0;
            end

            if (frame_done) begin
                if (!par_bad && vote) begin
                    o_data       <= shift_q;
                    o_data_valid <= 1'b1;
                end
                o_par_err  <= par_bad;
                o_stop_err <= !vote;
                wait_high  <= !vote && (shift_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed bench for uart_rx_fsm: a table of frames with hand-computed
// results, then hand-written sequences for glitch rejection, back-to-back
// frames after a stop error, line break and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          rx       = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          en_par   = 1'b0;
    logic          par_typ  = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          o_par_err;
    logic          o_stop_err;
    logic          o_busy;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRE_W(PW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_in      (rx),
        .i_prescale   (prescale),
        .i_en_par     (en_par),
        .i_par_typ    (par_typ),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_par_err    (o_par_err),
        .o_stop_err   (o_stop_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int vcnt = 0;
    int pcnt = 0;
    int scnt = 0;
    int vcyc = 0;
    int start_cyc = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_data_valid) begin
            vcnt <= vcnt + 1;
            vcyc <= cyc;
        end
        if (o_par_err)  pcnt <= pcnt + 1;
        if (o_stop_err) scnt <= scnt + 1;
    end

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         ep;
        bit         pt;
        logic       par_v;
        logic       stop_v;
        bit         flip;
        bit         exp_v;
        logic [7:0] exp_d;
        bit         exp_pe;
        bit         exp_se;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called on a falling edge; drives one bit for p cycles. With flip set,
    // the cycle the receiver uses as its middle sample is inverted.
    task automatic drive_bit(input logic b, input int p, input bit flip);
        for (int i = 0; i < p; i++) begin
            rx = (flip && i == p / 2 + 1) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit ep,
                              input logic par_v, input logic stop_v,
                              input bit flip, input int idle_n);
        start_cyc = cyc;
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i], p, flip);
        if (ep) drive_bit(par_v, p, 1'b0);
        drive_bit(stop_v, p, 1'b0);
        rx = 1'b1;
        repeat (idle_n) @(negedge clk);
    endtask

    int v0, p0, s0, s;

    initial begin
        //            d      p  ep pt par  stop flip  v  exp_d  pe se
        vecs[0] = '{8'hA5,  8, 0, 0, 1'b0, 1'b1, 0,   1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 16, 1, 0, 1'b0, 1'b1, 0,   1, 8'h3C, 0, 0};
        vecs[2] = '{8'h3C, 16, 1, 0, 1'b1, 1'b1, 0,   0, 8'h3C, 1, 0};
        vecs[3] = '{8'h96,  8, 1, 1, 1'b1, 1'b1, 0,   1, 8'h96, 0, 0};
        vecs[4] = '{8'h00, 32, 1, 1, 1'b0, 1'b1, 0,   0, 8'h96, 1, 0};
        vecs[5] = '{8'hFF, 32, 0, 0, 1'b0, 1'b1, 0,   1, 8'hFF, 0, 0};
        vecs[6] = '{8'hC3, 32, 0, 0, 1'b0, 1'b1, 1,   1, 8'hC3, 0, 0};
        vecs[7] = '{8'h5A,  8, 0, 0, 1'b0, 1'b0, 0,   0, 8'hC3, 0, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data",  32'(o_data), 32'h0);
        check("reset_valid", 32'(o_data_valid), 32'h0);
        check("reset_perr",  32'(o_par_err), 32'h0);
        check("reset_serr",  32'(o_stop_err), 32'h0);
        check("reset_busy",  32'(o_busy), 32'h0);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            prescale = vecs[i].p[PW-1:0];
            en_par   = vecs[i].ep;
            par_typ  = vecs[i].pt;
            @(negedge clk);
            v0 = vcnt; p0 = pcnt; s0 = scnt;
            send_frame(vecs[i].d, vecs[i].p, vecs[i].ep, vecs[i].par_v,
                       vecs[i].stop_v, vecs[i].flip, 8);
            check($sformatf("vec%0d_valid", i), vcnt - v0, 32'(vecs[i].exp_v));
            check($sformatf("vec%0d_perr", i),  pcnt - p0, 32'(vecs[i].exp_pe));
            check($sformatf("vec%0d_serr", i),  scnt - s0, 32'(vecs[i].exp_se));
            check($sformatf("vec%0d_data", i),  32'(o_data), 32'(vecs[i].exp_d));
            if (vecs[i].exp_v) begin
                check($sformatf("vec%0d_latency", i), vcyc - start_cyc - 1,
                      (DW + 2 + int'(vecs[i].ep)) * vecs[i].p + SL);
            end
        end

        // short low glitch on an idle line
        prescale = 6'd8;
        en_par   = 1'b0;
        par_typ  = 1'b0;
        @(negedge clk);
        v0 = vcnt; p0 = pcnt; s0 = scnt;
        s = cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_rise", 32'(o_busy), 32'h1);
        repeat (5 + SL) @(negedge clk);
        check("glitch_busy_hold", 32'(o_busy), 32'h1);
        @(negedge clk);
        check("glitch_busy_drop", 32'(o_busy), 32'h0);
        repeat (4) @(negedge clk);
        check("glitch_no_pulses", (vcnt - v0) + (pcnt - p0) + (scnt - s0), 32'h0);

        // stop error frame followed immediately by a good frame
        v0 = vcnt; p0 = pcnt; s0 = scnt;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        check("b2b_serr",  scnt - s0, 32'h1);
        check("b2b_valid", vcnt - v0, 32'h1);
        check("b2b_perr",  pcnt - p0, 32'h0);
        check("b2b_data",  32'(o_data), 32'h0F);

        // line break: one stop error, no retrigger while the line stays low
        v0 = vcnt; s0 = scnt;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        check("break_idle_low", 32'(o_busy), 32'h0);
        check("break_serr",     scnt - s0, 32'h1);
        check("break_valid",    vcnt - v0, 32'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_idle_high", 32'(o_busy), 32'h0);

        // reset during data bit 4 of 0x81, then a clean 0x81
        v0 = vcnt; p0 = pcnt; s0 = scnt;
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data",  32'(o_data), 32'h0);
        check("midrst_valid", 32'(o_data_valid), 32'h0);
        check("midrst_perr",  32'(o_par_err), 32'h0);
        check("midrst_serr",  32'(o_stop_err), 32'h0);
        check("midrst_busy",  32'(o_busy), 32'h0);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_pulses", (vcnt - v0) + (pcnt - p0) + (scnt - s0), 32'h0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        check("after_rst_valid", vcnt - v0, 32'h1);
        check("after_rst_data",  32'(o_data), 32'h81);
        check("after_rst_errs",  (pcnt - p0) + (scnt - s0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
